// File: rtl/mole_scheduler.sv
// Whack-a-mole game scheduler: free-running tick prescaler and LFSR drive an IDLE/PLAY/OVER game FSM.
// Optional macro WRONG_HIT_PENALTY_EN: in UP, presses on unlit moles also count as misses.
`timescale 1ns/1ps
module mole_scheduler #(
  parameter int unsigned TICK_DIV  = 50000000,
  parameter int unsigned UP_TICKS  = 4,
  parameter int unsigned GAP_TICKS = 2,
  parameter int unsigned MAX_MISS  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] hit,
  output logic [3:0] mole,
  output logic [7:0] score,
  output logic [3:0] miss,
  output logic       ingame,
  output logic       game_over
);

  localparam int unsigned PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned TMAX = (UP_TICKS > GAP_TICKS) ? UP_TICKS : GAP_TICKS;
  localparam int unsigned CW   = (TMAX > 1) ? $clog2(TMAX + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_OVER} state_t;

  state_t          state_q, state_d;
  logic            up_q, up_d;
  logic [CW-1:0]   tcnt_q, tcnt_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [7:0]      lfsr_q, lfsr_d;
  logic [3:0]      mole_q, mole_d;
  logic [7:0]      score_q, score_d;
  logic [3:0]      miss_q, miss_d;
  logic            tick;
  logic            hit_ok;
  logic [1:0]      miss_inc;
  logic [4:0]      miss_sum;

  assign tick    = (presc_q == PW'(TICK_DIV - 1));
  assign presc_d = tick ? '0 : presc_q + 1'b1;
  assign lfsr_d  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  // The lit lamp is one-hot, so masking the presses with it selects only the lit button.
  assign hit_ok  = |(hit & mole_q);

`ifdef WRONG_HIT_PENALTY_EN
  logic wrong_hit;
  assign wrong_hit = |(hit & ~mole_q);
`endif

  // A timeout and a wrong press may land together, so misses can step by two.
  assign miss_sum = {1'b0, miss_q} + {3'b000, miss_inc};

  always_comb begin
    state_d  = state_q;
    up_d     = up_q;
    tcnt_d   = tcnt_q;
    mole_d   = mole_q;
    score_d  = score_q;
    miss_inc = 2'd0;
    case (state_q)
      S_IDLE: begin
        mole_d = 4'b0000;
        if (start) begin
          state_d = S_PLAY;
          score_d = 8'd0;
          up_d    = 1'b0;
          tcnt_d  = '0;
        end
      end
      S_PLAY: begin
        if (32'(miss_q) >= MAX_MISS) begin
          state_d = S_OVER;
          mole_d  = 4'b1111;
        end else if (!up_q) begin
          if (tick) begin
            if (tcnt_q == CW'(GAP_TICKS - 1)) begin
              up_d   = 1'b1;
              mole_d = 4'b0001 << lfsr_q[1:0];
              tcnt_d = '0;
            end else begin
              tcnt_d = tcnt_q + 1'b1;
            end
          end
        end else begin
          if (hit_ok) begin
            mole_d  = 4'b0000;
            score_d = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
            up_d    = 1'b0;
            tcnt_d  = '0;
          end else if (tick) begin
            if (tcnt_q == CW'(UP_TICKS - 1)) begin
              mole_d   = 4'b0000;
              miss_inc = 2'd1;
              up_d     = 1'b0;
              tcnt_d   = '0;
            end else begin
              tcnt_d = tcnt_q + 1'b1;
            end
          end
`ifdef WRONG_HIT_PENALTY_EN
          if (wrong_hit) begin
            miss_inc = miss_inc + 2'd1;
          end
`endif
        end
      end
      S_OVER: begin
        mole_d = 4'b1111;
        if (start) begin
          state_d = S_PLAY;
          mole_d  = 4'b0000;
          score_d = 8'd0;
          up_d    = 1'b0;
          tcnt_d  = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        mole_d  = 4'b0000;
      end
    endcase
  end

  always_comb begin
    miss_d = (miss_sum > 5'd15) ? 4'd15 : miss_sum[3:0];
    if ((state_q != S_PLAY) && start) begin
      miss_d = 4'd0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      up_q    <= 1'b0;
      tcnt_q  <= '0;
      presc_q <= '0;
      lfsr_q  <= 8'hA5;
      mole_q  <= 4'b0000;
      score_q <= 8'd0;
      miss_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      up_q    <= up_d;
      tcnt_q  <= tcnt_d;
      presc_q <= presc_d;
      lfsr_q  <= lfsr_d;
      mole_q  <= mole_d;
      score_q <= score_d;
      miss_q  <= miss_d;
    end
  end

  assign mole      = mole_q;
  assign score     = score_q;
  assign miss      = miss_q;
  assign ingame    = (state_q == S_PLAY);
  assign game_over = (state_q == S_OVER);

endmodule

// File: tb/tb_mole_scheduler.sv
// Scoreboard bench for mole_scheduler: directed stimulus queues expected outputs per cycle, a monitor checks them.
`timescale 1ns/1ps
module tb_mole_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] hit;
  logic [3:0] mole;
  logic [7:0] score;
  logic [3:0] miss;
  logic       ingame;
  logic       game_over;

  mole_scheduler #(
    .TICK_DIV(4), .UP_TICKS(3), .GAP_TICKS(2), .MAX_MISS(3)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .hit(hit),
    .mole(mole), .score(score), .miss(miss),
    .ingame(ingame), .game_over(game_over)
  );

  always #5 clk = ~clk;

`ifdef WRONG_HIT_PENALTY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int T = (P == 1) ? 80 : 100;

  typedef struct {
    int         cyc;
    logic [3:0] mole;
    logic [7:0] score;
    logic [3:0] miss;
    logic       ingame;
    logic       go;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   rel = 0;
  int   vectors = 0;
  int   miscompares = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] lfsr_after(input int n);
    logic [7:0] v;
    v = 8'hA5;
    for (int i = 0; i < n; i++) v = {v[6:0], ^(v & 8'hB8)};
    return v;
  endfunction

  // Lamp lit by a selection made at edge n+1, i.e. from the LFSR value after n steps.
  function automatic logic [3:0] lit(input int n);
    logic [7:0] v;
    v = lfsr_after(n);
    return 4'b0001 << v[1:0];
  endfunction

  task automatic exp_abs(input int c, input logic [3:0] m, input int s, input int ms,
                         input logic ig, input logic go, input string nm);
    exp_t e;
    e.cyc = c; e.mole = m; e.score = 8'(s); e.miss = 4'(ms);
    e.ingame = ig; e.go = go; e.name = nm;
    sb.push_back(e);
  endtask

  task automatic exp_k(input int k, input logic [3:0] m, input int s, input int ms,
                       input logic ig, input logic go, input string nm);
    exp_abs(rel + k, m, s, ms, ig, go, nm);
  endtask

  task automatic goto(input int k);
    while (cyc < rel + k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_hit(input int k, input logic [3:0] v);
    goto(k - 1);
    hit = v;
    goto(k);
    hit = 4'b0000;
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      vectors++;
      if (e.cyc != cyc || mole !== e.mole || score !== e.score || miss !== e.miss ||
          ingame !== e.ingame || game_over !== e.go) begin
        miscompares++;
        $display("FAIL %s cyc=%0d: got mole=%b score=%0d miss=%0d ingame=%b game_over=%b, want mole=%b score=%0d miss=%0d ingame=%b game_over=%b (due cyc %0d)",
                 e.name, cyc, mole, score, miss, ingame, game_over,
                 e.mole, e.score, e.miss, e.ingame, e.go, e.cyc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got time %0t, want < 100000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] w;
    reset = 1'b1; start = 1'b0; hit = 4'b0000;
    exp_abs(1, 4'b0000, 0, 0, 1'b0, 1'b0, "reset_state");
    #22 reset = 1'b0;
    rel = cyc;

    exp_k(3, 4'b0000, 0, 0, 1'b0, 1'b0, "idle_hold");
    exp_k(4, 4'b0000, 0, 0, 1'b1, 1'b0, "start_play");
    goto(3); start = 1'b1; goto(4); start = 1'b0;
    vectors++;
    if (ingame !== 1'b1 || game_over !== 1'b0) begin
      miscompares++;
      $display("FAIL direct_start: got ingame=%b game_over=%b, want ingame=1 game_over=0", ingame, game_over);
    end else begin
      $display("PASS direct_start: ingame=%b game_over=%b", ingame, game_over);
    end

    exp_k(6, 4'b0000, 0, 0, 1'b1, 1'b0, "gap_hit_ignored");
    pulse_hit(6, 4'hF);
    exp_k(11, 4'b0000, 0, 0, 1'b1, 1'b0, "gap_dark");
    exp_k(12, lit(11), 0, 0, 1'b1, 1'b0, "first_mole");
    exp_k(14, 4'b0000, 1, 0, 1'b1, 1'b0, "hit_match");
    pulse_hit(14, lit(11));

    exp_k(20, lit(19), 1, 0, 1'b1, 1'b0, "second_mole");
    exp_k(26, lit(19), 1, P, 1'b1, 1'b0, "wrong_hit");
    w = ~lit(19);
    pulse_hit(26, w);
    exp_k(31, lit(19), 1, P, 1'b1, 1'b0, "pre_timeout");
    exp_k(32, 4'b0000, 2, P, 1'b1, 1'b0, "hit_on_timeout");
    pulse_hit(32, lit(19));

    exp_k(40, lit(39), 2, P, 1'b1, 1'b0, "third_mole");
    exp_k(51, lit(39), 2, P, 1'b1, 1'b0, "still_lit");
    exp_k(52, 4'b0000, 2, P + 1, 1'b1, 1'b0, "timeout_miss");

    exp_k(60, lit(59), 2, P + 1, 1'b1, 1'b0, "fourth_mole");
    exp_k(62, 4'b0000, 3, P + 1, 1'b1, 1'b0, "multi_hit");
`ifdef WRONG_HIT_PENALTY_EN
    pulse_hit(62, lit(59));
`else
    pulse_hit(62, 4'hF);
`endif

    exp_k(68, lit(67), 3, P + 1, 1'b1, 1'b0, "fifth_mole");
    exp_k(80, 4'b0000, 3, P + 2, 1'b1, 1'b0, "timeout_miss2");
`ifndef WRONG_HIT_PENALTY_EN
    exp_k(88, lit(87), 3, 2, 1'b1, 1'b0, "sixth_mole");
    exp_k(100, 4'b0000, 3, 3, 1'b1, 1'b0, "miss_max");
`endif
    exp_k(T + 1, 4'hF, 3, 3, 1'b0, 1'b1, "game_over");
    exp_k(T + 3, 4'hF, 3, 3, 1'b0, 1'b1, "over_hit_ignored");
    pulse_hit(T + 3, 4'hF);

    exp_k(T + 4, 4'b0000, 0, 0, 1'b1, 1'b0, "restart");
    exp_k(T + 6, 4'b0000, 0, 0, 1'b1, 1'b0, "start_in_play");
    goto(T + 3); start = 1'b1; goto(T + 6); start = 1'b0;
    vectors++;
    if (score !== 8'd0 || miss !== 4'd0 || ingame !== 1'b1) begin
      miscompares++;
      $display("FAIL direct_restart: got score=%0d miss=%0d ingame=%b, want score=0 miss=0 ingame=1", score, miss, ingame);
    end else begin
      $display("PASS direct_restart: score=%0d miss=%0d ingame=%b", score, miss, ingame);
    end

    exp_k(T + 12, lit(T + 11), 0, 0, 1'b1, 1'b0, "new_game_mole");
    exp_k(T + 13, 4'b0000, 1, 0, 1'b1, 1'b0, "new_game_hit");
    pulse_hit(T + 13, lit(T + 11));
    exp_k(T + 20, lit(T + 19), 1, 0, 1'b1, 1'b0, "mole_before_reset");
    exp_k(T + 21, 4'b0000, 0, 0, 1'b0, 1'b0, "async_reset");
    exp_k(T + 22, 4'b0000, 0, 0, 1'b0, 1'b0, "reset_held");
    goto(T + 21); #1 reset = 1'b1;
    #1;
    vectors++;
    if (mole !== 4'b0000 || score !== 8'd0 || miss !== 4'd0 || ingame !== 1'b0) begin
      miscompares++;
      $display("FAIL direct_async_reset: got mole=%b score=%0d miss=%0d ingame=%b, want mole=0000 score=0 miss=0 ingame=0",
               mole, score, miss, ingame);
    end else begin
      $display("PASS direct_async_reset: mole=%b score=%0d miss=%0d ingame=%b", mole, score, miss, ingame);
    end
    goto(T + 22); reset = 1'b0;
    rel = cyc;

    exp_k(2, 4'b0000, 0, 0, 1'b0, 1'b0, "idle_after_reset");
    exp_k(5, 4'b0000, 0, 0, 1'b0, 1'b0, "idle_no_start");
    goto(6);
    @(negedge clk);
    #1;
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      vectors++;
      miscompares++;
      $display("FAIL %s: got no check by cyc %0d, want checked at cyc %0d", e.name, cyc, e.cyc);
    end
    if (miscompares == 0) begin
      $display("PASS summary: %0d vectors, 0 miscompares", vectors);
    end else begin
      $display("FAIL summary: got %0d miscompares, want 0", miscompares);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
